conv_frame_ctrl: RTL and testbench
==================================

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 SHALL have parameter W, default 220, frame width in pixels.
REQ-002 SHALL have parameter H, default 220, frame height in pixels.
REQ-003 SHALL have parameter K, default 5, kernel size; W and H each SHALL be at least K.
REQ-004 SHALL have parameter LAT, default 2, number of datapath enable strobes from pixel accept to result on res_in.
REQ-005 SHALL have these ports, one per line:
  clk  in  1  single clock; all state updates on rising edge.
  reset  in  1  asynchronous, active-low.
  start  in  1  frame start request.
  src_valid  in  1  source pixel available.
  src_pxl  in  8  source pixel.
  src_ready  out  1  controller accepts pixel this cycle.
  conv_en  out  1  advance strobe for every convolution datapath register.
  conv_clr  out  1  synchronous clear for the convolution datapath.
  conv_pxl  out  8  pixel driven into the datapath.
  res_in  in  16  datapath result (absolute value).
  res_valid  out  1  res_data holds one valid window result.
  res_data  out  16  qualified result.
  busy  out  1  frame in progress.
  done  out  1  one-cycle end-of-frame pulse.
  row  out  8  row index of the next pixel to accept.
  col  out  8  column index of the next pixel to accept.

Function
REQ-006 SHALL implement the states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-007 In IDLE, start=1 SHALL move to CLEAR; start in any other state SHALL be ignored.
REQ-008 CLEAR SHALL last exactly 1 cycle, with conv_clr=1, row=0 and col=0, then move to STREAM.
REQ-009 In STREAM: src_ready=1; accept = src_valid&src_ready; conv_en=accept; conv_pxl=src_pxl.
REQ-010 When src_valid=0 in STREAM, conv_en SHALL be 0, the datapath SHALL stall, and no counter SHALL change.
REQ-011 On each accept, col SHALL increment; at col=W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-012 Accepting pixel (H-1, W-1) SHALL move to DRAIN; row and col SHALL then hold at 0.
REQ-013 DRAIN SHALL last exactly LAT cycles with conv_en=1, conv_pxl=0 and src_ready=0, then move to DONE.
REQ-014 DONE SHALL last 1 cycle with done=1, then move to IDLE.
REQ-015 busy SHALL be 1 in CLEAR, STREAM and DRAIN, and 0 otherwise.
REQ-016 An accepted pixel at (r,c) SHALL be tagged complete iff r>=K-1 and c>=K-1.
REQ-017 Tags SHALL travel through a LAT-deep tag pipeline that shifts only when conv_en=1.
REQ-018 res_valid SHALL be 1 in the cycle after the conv_en that moves a set tag out of the last stage, and 0 otherwise.
REQ-019 res_data SHALL equal res_in when res_valid=1, and 0 otherwise.
REQ-020 conv_clr SHALL clear the tag pipeline.
REQ-021 Each frame SHALL produce exactly (W-K+1)*(H-K+1) res_valid pulses; for the defaults that is 46656.
REQ-022 The last res_valid of a frame SHALL occur no later than the cycle done=1.
REQ-023 Row/col counters SHALL be sized to hold max(W,H)-1; values beyond the 8-bit ports are out of scope.

Reset
REQ-024 reset=0 SHALL, asynchronously: force state IDLE; clear the tag pipeline; and drive src_ready, conv_en, conv_clr, res_valid, busy and done to 0, and conv_pxl, res_data, row and col to 0.
REQ-025 reset asserted mid-frame SHALL abandon the frame; no done pulse SHALL follow.
REQ-026 After reset release, the next start SHALL pass through CLEAR before any pixel is accepted.

Verification (bench parameters W=8, H=6, K=3, LAT=2)
REQ-027 Scenario 1 SHALL be run: start, then src_valid held at 1 -> 48 accepts, 24 res_valid pulses, done 1 cycle after the 2 drain cycles, busy falls at done.
REQ-028 Scenario 2 SHALL be run: src_valid toggled 1/0 every cycle -> same 24 results in the same order, conv_en=0 on every idle cycle, and no counter change on idle cycles.
REQ-029 Scenario 3 SHALL be run: ramp pixels with an identity datapath model -> first res_valid tagged from pixel (2,2), none from columns 0-1 or rows 0-1.
REQ-030 Scenario 4 SHALL be run: reset pulsed low after 20 accepts -> all outputs 0 immediately and no done; a new start then yields the full 24 results.
REQ-031 Scenario 5 SHALL be run: start held at 1 throughout the frame -> exactly one frame runs; a second frame starts only after returning to IDLE.
REQ-032 Scenario 6 SHALL be run: two back-to-back frames -> conv_clr=1 for exactly 1 cycle before each, and each frame produces 24 results.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a KxK convolution datapath: streams one WxH frame,
// drains the datapath pipeline and qualifies full-window results.
module conv_frame_ctrl #(
    parameter int W   = 220,
    parameter int H   = 220,
    parameter int K   = 5,
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        src_valid,
    input  logic [7:0]  src_pxl,
    output logic        src_ready,
    output logic        conv_en,
    output logic        conv_clr,
    output logic [7:0]  conv_pxl,
    input  logic [15:0] res_in,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  row,
    output logic [7:0]  col
);

    localparam int MAXD = (W > H) ? W : H;
    localparam int CW   = (MAXD > 2) ? $clog2(MAXD) : 1;
    localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  row_q;
    logic [CW-1:0]  col_q;
    logic [DW-1:0]  dcnt;
    logic [LAT-1:0] tag;
    logic           ready_q;
    logic           drain_q;
    logic           clr_q;
    logic           busy_q;
    logic           done_q;
    logic           rv_q;
    logic           accept;
    logic           last_col;
    logic           last_row;
    logic           win;

    assign accept   = ready_q & src_valid;
    assign last_col = (col_q == CW'(W - 1));
    assign last_row = (row_q == CW'(H - 1));
    assign win      = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));

    // Drain strobes push zeros so the last window reaches res_in.
    assign conv_en   = accept | drain_q;
    assign conv_pxl  = ready_q ? src_pxl : 8'd0;
    assign conv_clr  = clr_q;
    assign src_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = rv_q;
    assign res_data  = rv_q ? res_in : 16'd0;
    assign row       = 8'(row_q);
    assign col       = 8'(col_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            dcnt    <= '0;
            ready_q <= 1'b0;
            drain_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CLEAR;
                        clr_q  <= 1'b1;
                        busy_q <= 1'b1;
                        row_q  <= '0;
                        col_q  <= '0;
                    end
                end
                CLEAR: begin
                    state   <= STREAM;
                    clr_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                STREAM: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                state   <= DRAIN;
                                row_q   <= '0;
                                ready_q <= 1'b0;
                                drain_q <= 1'b1;
                                dcnt    <= '0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DW'(LAT - 1)) begin
                        state   <= DONE;
                        drain_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window tags follow their pixel through the datapath latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag  <= '0;
            rv_q <= 1'b0;
        end else if (clr_q) begin
            tag  <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= conv_en & tag[LAT-1];
            if (conv_en) begin
                tag <= (tag << 1) | LAT'(accept & win);
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomized scoreboard bench for conv_frame_ctrl with an identity
// datapath model (LAT+1 enabled register stages feeding res_in).
module tb_conv_frame_ctrl;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int K    = 3;
    localparam int LAT  = 2;
    localparam int NPIX = W * H;
    localparam int NRES = (W - K + 1) * (H - K + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        src_valid;
    logic [7:0]  src_pxl;
    logic        src_ready;
    logic        conv_en;
    logic        conv_clr;
    logic [7:0]  conv_pxl;
    logic [15:0] res_in;
    logic        res_valid;
    logic [15:0] res_data;
    logic        busy;
    logic        done;
    logic [7:0]  row;
    logic [7:0]  col;

    conv_frame_ctrl #(.W(W), .H(H), .K(K), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_valid (src_valid),
        .src_pxl   (src_pxl),
        .src_ready (src_ready),
        .conv_en   (conv_en),
        .conv_clr  (conv_clr),
        .conv_pxl  (conv_pxl),
        .res_in    (res_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done),
        .row       (row),
        .col       (col)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails = 0;
    int          res_cnt = 0;
    int          clr_cnt = 0;
    int          done_cnt = 0;
    int          acc_n = 0;
    int          first_res = -1;
    bit          hold_start = 1'b0;
    logic [7:0]  pix [NPIX];
    logic [15:0] exp_q [$];
    logic [15:0] mon_e;
    logic [7:0]  dp [LAT+1];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Identity datapath: a pixel reaches res_in LAT strobes after its accept.
    always @(posedge clk) begin
        if (conv_clr) begin
            for (int i = 0; i <= LAT; i++) dp[i] <= 8'd0;
        end else if (conv_en) begin
            dp[0] <= conv_pxl;
            for (int i = 1; i <= LAT; i++) dp[i] <= dp[i-1];
        end
    end
    assign res_in = {8'h00, dp[LAT]};

    always @(negedge clk) begin
        if (reset) begin
            if (conv_clr) begin
                clr_cnt++;
                acc_n = 0;
                first_res = -1;
                chk("clear_rowcol", {row, col}, 0);
            end else if (busy && src_ready) begin
                chk("row", row, acc_n / W);
                chk("col", col, acc_n % W);
                if (src_valid) acc_n++;
            end
            if (done) done_cnt++;
            if (res_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL res_extra: got %0h, expected no result",
                             res_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (res_data !== mon_e) begin
                        fails++;
                        $display("FAIL res_data: got %0h, expected %0h",
                                 res_data, mon_e);
                    end
                end
                res_cnt++;
                if (first_res < 0) first_res = int'(res_data);
            end else begin
                chk("res_idle_zero", res_data, 0);
            end
        end
    end

    task automatic do_reset_mid();
        int dc;
        @(posedge clk);
        #1 src_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk("reset_outputs",
               {src_ready, conv_en, conv_clr, res_valid, busy, done,
                conv_pxl, res_data, row, col}, 0);
        dc = done_cnt;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_done_after_reset", done_cnt, dc);
        chk("idle_after_reset", {busy, conv_clr, src_ready}, 0);
        exp_q.delete();
        res_cnt = 0;
        clr_cnt = 0;
    endtask

    // mode 0: continuous, 1: toggled valid, 2: ramp, 3: reset after 20
    task automatic run_frame(input int mode, input bit issue);
        int idx;
        int cyc;
        bit got;
        for (int i = 0; i < NPIX; i++)
            pix[i] = (mode == 2) ? 8'(i) : 8'($urandom_range(0, 255));
        for (int r = K - 1; r < H; r++)
            for (int c = K - 1; c < W; c++)
                exp_q.push_back({8'h00, pix[r*W+c]});
        if (issue) begin
            @(posedge clk);
            #1 start = 1'b1;
        end
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (conv_clr) got = 1'b1;
        end
        chk("clear_seen", got, 1);
        if (!got) return;
        chk("clear_state", {busy, src_ready, conv_en, done}, 4'b1000);
        idx = 0;
        cyc = 0;
        while (idx < NPIX && cyc < 400) begin
            @(posedge clk);
            #1;
            start = hold_start;
            src_valid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            src_pxl = pix[idx];
            cyc++;
            @(negedge clk);
            if (!src_valid && src_ready) chk("idle_conv_en", conv_en, 0);
            if (src_valid && src_ready) begin
                chk("conv_pxl", conv_pxl, pix[idx]);
                idx++;
            end
            if (mode == 3 && idx == 20) begin
                do_reset_mid();
                return;
            end
        end
        chk("accepts_in_budget", idx, NPIX);
        if (idx != NPIX) return;
        for (int d = 0; d < LAT; d++) begin
            @(posedge clk);
            #1;
            src_valid = 1'($urandom_range(0, 1));
            src_pxl = 8'($urandom_range(1, 255));
            @(negedge clk);
            chk("drain", {conv_en, src_ready, busy, done}, 4'b1010);
            chk("drain_pxl", conv_pxl, 0);
        end
        @(posedge clk);
        #1 src_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", {done, busy, src_ready, conv_en}, 4'b1000);
        @(negedge clk);
        chk("after_done", {done, busy, conv_clr}, 0);
        chk("results", res_cnt, NRES);
        chk("queue_empty", exp_q.size(), 0);
        chk("clr_cycles", clr_cnt, 1);
        chk("accepts", acc_n, NPIX);
        if (mode == 2) chk("first_res", first_res, 2 * W + 2);
        res_cnt = 0;
        clr_cnt = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        src_valid = 1'b0;
        src_pxl = 8'd0;
        #3 chk("reset_state",
               {src_ready, conv_en, conv_clr, res_valid, busy, done,
                conv_pxl, res_data, row, col}, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        run_frame(0, 1'b1);
        run_frame(1, 1'b1);
        run_frame(2, 1'b1);
        run_frame(3, 1'b1);
        run_frame(0, 1'b1);
        hold_start = 1'b1;
        run_frame(0, 1'b1);
        hold_start = 1'b0;
        run_frame(0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stays_idle", {busy, conv_clr}, 0);
        end
        run_frame(0, 1'b1);
        run_frame(0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
